// File: rtl/seg_scan_pkg.sv
// Shared types, glyph table and helpers for the multiplexed 7-segment driver.
package seg_scan_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Active-high glyphs, bit 0 = segment A ... bit 6 = segment G.
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Decimal digits needed to hold the largest unsigned value of the given width.
  function automatic int bcd_digits(input int width);
    longint maxv;
    longint p;
    int     n;
    maxv = (longint'(1) << width) - 1;
    p    = 10;
    n    = 1;
    for (int i = 0; i < 10; i++) begin
      if (p <= maxv) begin
        n++;
        p = p * 10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one bit per cycle, then a
// single commit cycle in which bcd/ovf are valid alongside done.
module bin2bcd_seq
  import seg_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  // Convert to the full decimal width so overflow falls out of the upper digits.
  localparam int NB_MIN = bcd_digits(DATA_WIDTH);
  localparam int NB     = (NB_MIN > DIGITS) ? NB_MIN : DIGITS;
  localparam int BW     = 4 * NB;
  localparam int CW     = $clog2(DATA_WIDTH + 1);

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [BW+DATA_WIDTH-1:0]   sh_q, sh_d, adj;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    adj     = sh_q;
    for (int j = 0; j < NB; j++) begin
      if (sh_q[DATA_WIDTH+4*j +: 4] >= 4'd5)
        adj[DATA_WIDTH+4*j +: 4] = sh_q[DATA_WIDTH+4*j +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = {BW'(0), bin};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = adj << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    ovf = 1'b0;
    for (int j = DIGITS; j < NB; j++) ovf = ovf | (|sh_q[DATA_WIDTH+4*j +: 4]);
  end

  assign bcd  = sh_q[DATA_WIDTH +: 4*DIGITS];
  assign busy = (state_q != IDLE);
  assign done = (state_q == COMMIT);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with hex/decimal display, leading-zero
// blanking, live radix points and overflow dashes. SEG_SCAN_BRIGHTNESS_EN adds bright[3:0].
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     dp,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input  logic [3:0]            bright,
`endif
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  busy,
  output logic                  overflow
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PR_W  = $clog2(REFRESH_DIV);
  localparam int XW    = DATA_WIDTH + 4 * DIGITS;

  logic [PR_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]      sel_q, sel_d;
  logic [7:0]             seg_q, seg_d;
  logic [DIGITS-1:0][3:0] dig_q, dig_d;
  logic                   ovf_q, ovf_d;
  logic                   blank_q, blank_d;
  logic                   conv_blank_q, conv_blank_d;
  logic                   pend_q, pend_d;
  logic                   pend_mode_q, pend_mode_d;
  logic                   pend_blank_q, pend_blank_d;
  logic [DATA_WIDTH-1:0]  pend_data_q, pend_data_d;

  logic                   req_v, req_mode, req_blank;
  logic [DATA_WIDTH-1:0]  req_data;
  logic [XW-1:0]          req_ext;
  logic                   hex_ovf;
  logic                   cv_start, cv_busy, cv_done, cv_ovf;
  logic [4*DIGITS-1:0]    cv_bcd;

  logic [DIGITS-1:0]      lz;
  logic                   zero_run;
  logic [6:0]             glyph;

  bin2bcd_seq #(
    .DATA_WIDTH(DATA_WIDTH),
    .DIGITS    (DIGITS)
  ) u_bcd (
    .clk  (clk),
    .rst  (rst),
    .start(cv_start),
    .bin  (req_data),
    .busy (cv_busy),
    .done (cv_done),
    .bcd  (cv_bcd),
    .ovf  (cv_ovf)
  );

  // A load while converting parks in the pending slot; it is replayed the
  // first idle cycle. A fresh load in that same cycle supersedes it.
  always_comb begin
    pend_d       = pend_q;
    pend_data_d  = pend_data_q;
    pend_mode_d  = pend_mode_q;
    pend_blank_d = pend_blank_q;
    req_v        = 1'b0;
    req_data     = data;
    req_mode     = mode;
    req_blank    = blank_lz;
    if (cv_busy) begin
      if (load) begin
        pend_d       = 1'b1;
        pend_data_d  = data;
        pend_mode_d  = mode;
        pend_blank_d = blank_lz;
      end
    end else if (load) begin
      req_v  = 1'b1;
      pend_d = 1'b0;
    end else if (pend_q) begin
      req_v     = 1'b1;
      req_data  = pend_data_q;
      req_mode  = pend_mode_q;
      req_blank = pend_blank_q;
      pend_d    = 1'b0;
    end
  end

  // Digit register, overflow and blanking flag always change together.
  always_comb begin
    req_ext      = XW'(req_data);
    hex_ovf      = |(req_ext >> (4 * DIGITS));
    dig_d        = dig_q;
    ovf_d        = ovf_q;
    blank_d      = blank_q;
    conv_blank_d = conv_blank_q;
    cv_start     = 1'b0;
    if (cv_done) begin
      dig_d   = cv_bcd;
      ovf_d   = cv_ovf;
      blank_d = conv_blank_q;
    end else if (req_v) begin
      if (req_mode == MODE_DEC) begin
        cv_start     = 1'b1;
        conv_blank_d = req_blank;
      end else begin
        dig_d   = req_ext[4*DIGITS-1:0];
        ovf_d   = hex_ovf;
        blank_d = req_blank;
      end
    end
  end

  always_comb begin
    presc_d = presc_q + PR_W'(1);
    idx_d   = idx_q;
    if (presc_q == PR_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [3:0]  bright_q, bright_d;
  logic [39:0] duty_thr;

  always_comb begin
    bright_d = bright_q;
    if (presc_q == PR_W'(REFRESH_DIV - 1)) bright_d = bright;
    duty_thr = ((40'(bright_q) + 40'd1) * 40'(REFRESH_DIV)) >> 4;
  end

  always_ff @(posedge clk) begin
    if (rst) bright_q <= 4'hF;
    else     bright_q <= bright_d;
  end
`endif

  // Digit 0 is never blanked, so a zero value still shows one "0".
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run & (dig_q[k] == 4'd0);
      lz[k]    = blank_q & zero_run;
    end
    glyph = SEG_HEX[dig_q[idx_q]];
    if (ovf_q)           glyph = SEG_DASH;
    else if (lz[idx_q])  glyph = SEG_BLANK;
    seg_d = ~{dp[idx_q], glyph};
    sel_d = ~(DIGITS'(1) << idx_q);
`ifdef SEG_SCAN_BRIGHTNESS_EN
    if (40'(presc_q) >= duty_thr) sel_d = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      sel_q        <= '1;
      seg_q        <= '1;
      dig_q        <= '0;
      ovf_q        <= 1'b0;
      blank_q      <= 1'b0;
      conv_blank_q <= 1'b0;
      pend_q       <= 1'b0;
      pend_data_q  <= '0;
      pend_mode_q  <= MODE_HEX;
      pend_blank_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      ovf_q        <= ovf_d;
      blank_q      <= blank_d;
      conv_blank_q <= conv_blank_d;
      pend_q       <= pend_d;
      pend_data_q  <= pend_data_d;
      pend_mode_q  <= pend_mode_d;
      pend_blank_q <= pend_blank_d;
    end
  end

  assign sel      = sel_q;
  assign seg      = seg_q;
  assign busy     = cv_busy;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (DIGITS=4, DATA_WIDTH=16, REFRESH_DIV=8).
module tb_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int DW     = 16;
  localparam int RD     = 8;

  logic              clk = 1'b0;
  logic              rst, load, mode, blank_lz;
  logic [DW-1:0]     data;
  logic [DIGITS-1:0] dp, sel;
  logic [7:0]        seg;
  logic              busy, overflow;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [3:0]        bright = 4'hF;
`endif

  int n_chk = 0;
  int n_bad = 0;

  seg_scan_driver #(
    .DIGITS     (DIGITS),
    .DATA_WIDTH (DW),
    .REFRESH_DIV(RD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .load    (load),
    .mode    (mode),
    .blank_lz(blank_lz),
    .dp      (dp),
`ifdef SEG_SCAN_BRIGHTNESS_EN
    .bright  (bright),
`endif
    .sel     (sel),
    .seg     (seg),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic m, input logic b);
    data     = d;
    mode     = m;
    blank_lz = b;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // Enter the slot of digit d from its start, settle two cycles, check seg.
  task automatic see_digit(input int d, input logic [7:0] exp, input string tag);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << d);
    n = 0;
    while (sel == want && n < 80) begin step(); n++; end
    while (sel != want && n < 80) begin step(); n++; end
    step();
    step();
    chk({tag, "_sel"}, sel, want);
    chk(tag, seg, exp);
  endtask

  function automatic int sel_idx(input logic [3:0] s);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (!s[i]) r = i;
    return r;
  endfunction

  function automatic logic [7:0] g1234(input int i);
    case (i)
      0:       return 8'h99;
      1:       return 8'hB0;
      2:       return 8'hA4;
      3:       return 8'hF9;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] w;
    int         n;
    logic       seen;

    rst = 1'b1; load = 1'b0; data = '0; mode = 1'b0; blank_lz = 1'b0; dp = '0;
    repeat (3) step();
    chk("rst_sel", sel, 4'hF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);

    // Free-run scan: 8 clocks per slot, digit 0 first, all showing "0".
    rst = 1'b0;
    step();
    for (int c = 0; c < 64; c++) begin
      if (c % 8 == 0 || c % 8 == 7) begin
        w = ~(4'b0001 << ((c / 8) % 4));
        chk("scan_sel", sel, w);
        chk("scan_seg", seg, 8'hC0);
      end
      step();
    end

    // Hex load: one-cycle latency, no busy.
    do_load(16'h1234, 1'b0, 1'b0);
    chk("hex_old", seg, 8'hC0);
    chk("hex_busy", busy, 1'b0);
    step();
    chk("hex_new", seg, g1234(sel_idx(sel)));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin seen = seen | busy; step(); end
    chk("hex_nobusy", seen, 1'b0);
    see_digit(0, 8'h99, "hex_d0");
    see_digit(1, 8'hB0, "hex_d1");
    see_digit(2, 8'hA4, "hex_d2");
    see_digit(3, 8'hF9, "hex_d3");
    chk("hex_ovf", overflow, 1'b0);

    // Decimal 9999: busy 17 cycles, display switches atomically at cycle 18.
    do_load(16'd9999, 1'b1, 1'b0);
    n = 0;
    while (busy && n < 40) begin step(); n++; end
    chk("dec_busy_len", n, 17);
    chk("dec_lat_old", seg, g1234(sel_idx(sel)));
    step();
    chk("dec_lat_new", seg, 8'h90);
    see_digit(3, 8'h90, "dec_d3");
    see_digit(0, 8'h90, "dec_d0");
    chk("dec_ovf", overflow, 1'b0);

    // Decimal 10000 does not fit in four digits: dashes everywhere.
    do_load(16'd10000, 1'b1, 1'b0);
    wait_idle("ovf_idle");
    step();
    chk("ovf_flag", overflow, 1'b1);
    for (int d = 0; d < 4; d++) see_digit(d, 8'hBF, "ovf_dash");

    // Decimal 7 with leading-zero blanking and a radix point on digit 2.
    dp = 4'b0100;
    do_load(16'd7, 1'b1, 1'b1);
    wait_idle("lz_idle");
    step();
    chk("lz_ovf", overflow, 1'b0);
    see_digit(3, 8'hFF, "lz_d3");
    see_digit(2, 8'h7F, "lz_d2");
    see_digit(1, 8'hFF, "lz_d1");
    see_digit(0, 8'hF8, "lz_d0");
    blank_lz = 1'b0;
    see_digit(3, 8'hFF, "lz_live");
    dp = '0;

    // Hex load parked while converting 500, applied right after commit.
    do_load(16'd500, 1'b1, 1'b0);
    repeat (4) step();
    do_load(16'h00AB, 1'b0, 1'b0);
    wait_idle("pend_idle");
    step();
    step();
    chk("pend_busy", busy, 1'b0);
    see_digit(0, 8'h83, "pend_d0");
    see_digit(1, 8'h88, "pend_d1");
    see_digit(2, 8'hC0, "pend_d2");
    see_digit(3, 8'hC0, "pend_d3");

    // Reset mid-conversion with a pending load: everything discarded.
    do_load(16'd500, 1'b1, 1'b0);
    repeat (4) step();
    do_load(16'h00AB, 1'b0, 1'b0);
    repeat (4) step();
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    chk("mid_rst_sel", sel, 4'hF);
    chk("mid_rst_seg", seg, 8'hFF);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin seen = seen | busy; step(); end
    chk("mid_nobusy", seen, 1'b0);
    see_digit(0, 8'hC0, "mid_d0");
    see_digit(1, 8'hC0, "mid_d1");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
